// File: rtl/hierInclude_package.sv
// Shared types for the hierInclude design: the aSt record and its field types.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hierInclude_package;

  // Number of aBiggerT elements carried in aSt.variablea2.
  localparam int ASIZE2 = 11;

  typedef logic [6:0]  aSizeT;
  typedef logic [3:0]  anotherSizeT;
  typedef logic [7:0]  yetAnotherSizeT;
  typedef logic [10:0] aBiggerT;

  // 7 + 4 + 8 + 11*11 = 140 bits. variablea2[0] occupies the LSBs.
  typedef struct packed {
    aSizeT                variablea;
    anotherSizeT          another;
    yetAnotherSizeT       yetAnother;
    aBiggerT [ASIZE2-1:0] variablea2;
  } aSt;

endpackage

// File: rtl/a_st_assembler.sv
// Purpose: builds one aSt record from a header beat plus ASIZE2 aBiggerT words.
// Latency: out_valid rises the cycle after the last word; min record period 13 cycles.
// Backpressure: valid/ready on every port; one record in flight, EMIT holds until out_ready.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   hdr_valid/hdr_ready, hdr_*    header beat (variablea, another, yetAnother)
//   word_valid/word_ready, word_data  payload words, element 0 first
//   out_valid/out_ready, out_data     assembled aSt record
//   assembled_count               records emitted (only with A_ST_ASSEMBLER_STATS_EN)
//
// Build option: define A_ST_ASSEMBLER_STATS_EN to add the STATS_W-bit
// assembled_count register and port.
module a_st_assembler
  import hierInclude_package::*;
#(
  parameter int unsigned STATS_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           hdr_valid,
  output logic           hdr_ready,
  input  aSizeT          hdr_variablea,
  input  anotherSizeT    hdr_another,
  input  yetAnotherSizeT hdr_yet_another,
  input  logic           word_valid,
  output logic           word_ready,
  input  aBiggerT        word_data,
  output logic           out_valid,
  input  logic           out_ready,
  output aSt             out_data
`ifdef A_ST_ASSEMBLER_STATS_EN
  ,
  output logic [STATS_W-1:0] assembled_count
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EMIT    = 2'd2
  } state_e;

  localparam logic [3:0] IdxLast = 4'(ASIZE2 - 1);

  state_e     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  aSt         rec_q, rec_d;
  logic       out_fire;

  // A zero-width counter is meaningless; keep STATS_W at 1 or more.
  if (STATS_W == 0) begin : g_stats_w_zero_unsupported
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rec_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rec_q   <= rec_d;
    end
  end

  // Handshake outputs depend only on state_q; inputs steer next-state only,
  // so there is no combinational input-to-output path.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rec_d      = rec_q;
    hdr_ready  = 1'b0;
    word_ready = 1'b0;
    out_valid  = 1'b0;
    out_fire   = 1'b0;

    case (state_q)
      IDLE: begin
        hdr_ready = 1'b1;
        if (hdr_valid) begin
          rec_d.variablea  = hdr_variablea;
          rec_d.another    = hdr_another;
          rec_d.yetAnother = hdr_yet_another;
          idx_d            = '0;
          state_d          = COLLECT;
        end
      end

      COLLECT: begin
        word_ready = 1'b1;
        if (word_valid) begin
          // Only the addressed element changes; older elements are left as-is
          // and are overwritten before out_valid can expose them.
          rec_d.variablea2[idx_q] = word_data;
          if (idx_q == IdxLast) begin
            idx_d   = '0;
            state_d = EMIT;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end

      EMIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          out_fire = 1'b1;
          state_d  = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign out_data = rec_q;

`ifdef A_ST_ASSEMBLER_STATS_EN
  logic [STATS_W-1:0] count_q, count_d;

  // Free-running record counter; wraps naturally from all-ones to zero.
  always_comb begin
    count_d = count_q;
    if (out_fire) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign assembled_count = count_q;
`endif

`ifndef SYNTHESIS
  // The word index only ever walks 0..ASIZE2-1.
  a_idx_in_range : assert property (@(posedge clk) disable iff (rst) idx_q <= IdxLast);
`endif

endmodule
